// File: rtl/perceptron_train_ctrl.sv
// ---------------------------------------------------------------------------
// perceptron_train_ctrl
//
// Sequencer and trainer for an N_IN-input binary perceptron. A sample (binary
// feature vector, target label, train flag) is accepted in IDLE. The signed
// weights of the set inputs are then summed serially, one input per cycle. The
// sum is compared against a signed threshold and the result is reported. In
// train mode a wrong answer triggers the perceptron learning rule (step 1,
// saturating) on the internal weight file.
//
// Handshake: a sample transfers on any rising edge where s_valid && s_ready.
// s_ready is high only in IDLE while clear_w is low. The controller never
// stalls on the result side: r_valid is a single-cycle strobe with no ready.
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   asynchronous, active-high reset
//   s_valid    in   sample valid
//   s_ready    out  controller can accept a sample
//   s_in       in   binary feature vector [N_IN]
//   s_label    in   target output (used in train mode)
//   s_train    in   1 = infer and update on error, 0 = infer only
//   threshold  in   signed threshold, sampled in DECIDE
//   clear_w    in   zero weights and err_count (IDLE only)
//   r_valid    out  one-cycle result strobe
//   r_result   out  perceptron output, held until the next r_valid
//   r_error    out  training mismatch flag, held until the next r_valid
//   err_count  out  saturating count of training errors
//   busy       out  controller is not in IDLE
//   w_sel      in   weight readback index
//   w_rd       out  w[w_sel], or 0 when w_sel is out of range
// ---------------------------------------------------------------------------
module perceptron_train_ctrl #(
    parameter int N_IN      = 8,
    parameter int W_WIDTH   = 8,
    parameter int ACC_WIDTH = 12
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [N_IN-1:0]    s_in,
    input  logic               s_label,
    input  logic               s_train,
    input  logic [W_WIDTH-1:0] threshold,
    input  logic               clear_w,
    output logic               r_valid,
    output logic               r_result,
    output logic               r_error,
    output logic [7:0]         err_count,
    output logic               busy,
    input  logic [2:0]         w_sel,
    output logic [W_WIDTH-1:0] w_rd
);

    localparam int IDX_W = (N_IN > 1) ? $clog2(N_IN) : 1;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCUM  = 2'd1;
    localparam logic [1:0] DECIDE = 2'd2;
    localparam logic [1:0] UPDATE = 2'd3;

    localparam logic signed [W_WIDTH-1:0] W_MAX = {1'b0, {(W_WIDTH-1){1'b1}}};
    localparam logic signed [W_WIDTH-1:0] W_MIN = {1'b1, {(W_WIDTH-1){1'b0}}};
    localparam logic signed [W_WIDTH-1:0] W_ONE = W_WIDTH'(1);

    // FSM state; readable hierarchically by checkers
    logic [1:0]                  state;

    logic [N_IN-1:0]             in_q;
    logic                        label_q;
    logic                        train_q;
    logic signed [ACC_WIDTH-1:0] acc;
    logic [IDX_W-1:0]            idx;
    logic signed [W_WIDTH-1:0]   w [N_IN];
    logic                        result_q;
    logic                        error_q;
    logic [7:0]                  err_cnt_q;

    logic                        take;
    logic                        do_clear;
    logic                        decide_result;
    logic                        decide_error;
    logic signed [ACC_WIDTH-1:0] thr_ext;
    logic signed [ACC_WIDTH-1:0] w_ext;

    // ------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------
    // clear_w wins over a simultaneous s_valid by dropping s_ready
    assign s_ready  = (state == IDLE) && !clear_w;
    assign take     = s_valid && s_ready;
    assign do_clear = (state == IDLE) && clear_w;
    assign busy     = (state != IDLE);
    assign r_valid  = (state == DECIDE);

    assign thr_ext = {{(ACC_WIDTH-W_WIDTH){threshold[W_WIDTH-1]}}, threshold};
    assign w_ext   = {{(ACC_WIDTH-W_WIDTH){w[idx][W_WIDTH-1]}}, w[idx]};

    assign decide_result = (acc >= thr_ext);
    assign decide_error  = train_q && (decide_result != label_q);

    // During DECIDE the live decision is shown so that it lines up with the
    // r_valid strobe; afterwards the copy registered on the exit edge is held.
    assign r_result  = (state == DECIDE) ? decide_result : result_q;
    assign r_error   = (state == DECIDE) ? decide_error  : error_q;
    assign err_count = err_cnt_q;

    always_comb begin
        w_rd = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (int'(w_sel) == i) begin
                w_rd = w[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Sequencer: state, captured sample, accumulator, result, error count
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            in_q      <= '0;
            label_q   <= 1'b0;
            train_q   <= 1'b0;
            acc       <= '0;
            idx       <= '0;
            result_q  <= 1'b0;
            error_q   <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (do_clear) begin
                        err_cnt_q <= '0;
                    end else if (take) begin
                        in_q    <= s_in;
                        label_q <= s_label;
                        train_q <= s_train;
                        acc     <= '0;
                        idx     <= '0;
                        state   <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (in_q[idx]) begin
                        acc <= acc + w_ext;
                    end
                    if (idx == IDX_W'(N_IN-1)) begin
                        idx   <= '0;
                        state <= DECIDE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DECIDE: begin
                    result_q <= decide_result;
                    error_q  <= decide_error;
                    state    <= decide_error ? UPDATE : IDLE;
                end
                UPDATE: begin
                    if (err_cnt_q != 8'hFF) begin
                        err_cnt_q <= err_cnt_q + 8'd1;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Weight file: cleared on request, stepped only in UPDATE
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_IN; i++) begin
                w[i] <= '0;
            end
        end else if (do_clear) begin
            for (int i = 0; i < N_IN; i++) begin
                w[i] <= '0;
            end
        end else if (state == UPDATE) begin
            for (int i = 0; i < N_IN; i++) begin
                if (in_q[i]) begin
                    // step toward the label, pinned at the signed range limits
                    if (label_q) begin
                        if (w[i] != W_MAX) begin
                            w[i] <= w[i] + W_ONE;
                        end
                    end else begin
                        if (w[i] != W_MIN) begin
                            w[i] <= w[i] - W_ONE;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_perceptron_train_ctrl.sv
// ---------------------------------------------------------------------------
// tb_perceptron_train_ctrl
//
// Directed bench for perceptron_train_ctrl. Each scenario task drives its own
// stimulus and compares against hand-computed values. Inputs change 1 time
// unit after the rising edge and outputs are sampled there as well.
// ---------------------------------------------------------------------------
module tb_perceptron_train_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       s_valid;
    logic       s_ready;
    logic [7:0] s_in;
    logic       s_label;
    logic       s_train;
    logic [7:0] threshold;
    logic       clear_w;
    logic       r_valid;
    logic       r_result;
    logic       r_error;
    logic [7:0] err_count;
    logic       busy;
    logic [2:0] w_sel;
    logic [7:0] w_rd;

    int n_checks = 0;
    int n_fails  = 0;

    perceptron_train_ctrl #(.N_IN(8), .W_WIDTH(8), .ACC_WIDTH(12)) dut (
        .clk       (clk),
        .reset     (reset),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_in      (s_in),
        .s_label   (s_label),
        .s_train   (s_train),
        .threshold (threshold),
        .clear_w   (clear_w),
        .r_valid   (r_valid),
        .r_result  (r_result),
        .r_error   (r_error),
        .err_count (err_count),
        .busy      (busy),
        .w_sel     (w_sel),
        .w_rd      (w_rd)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic read_w(input int i, output logic [7:0] v);
        w_sel = 3'(i);
        tick();
        v = w_rd;
    endtask

    // Offers one sample once s_ready is seen, then scrambles s_in/s_label
    // while busy. Reports the cycle (relative to the handshake cycle T0) of
    // the first r_valid and of the return of s_ready, plus the result seen.
    task automatic run_sample(input logic [7:0] in, input logic lab, input logic trn,
                              input logic [7:0] thr, output int rv_t, output int rdy_t,
                              output logic res, output logic err);
        int n;
        n = 0;
        rv_t = -1;
        rdy_t = -1;
        res = 1'bx;
        err = 1'bx;
        while (s_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        s_in = in;
        s_label = lab;
        s_train = trn;
        threshold = thr;
        s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
        s_in = ~in;
        s_label = ~lab;
        for (int t = 1; t <= 15; t++) begin
            if (r_valid === 1'b1 && rv_t < 0) begin
                rv_t = t;
                res = r_result;
                err = r_error;
            end
            if (s_ready === 1'b1) begin
                rdy_t = t;
                break;
            end
            tick();
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [7:0] v;
        reset = 1'b1;
        s_valid = 1'b0;
        s_in = '0;
        s_label = 1'b0;
        s_train = 1'b0;
        threshold = '0;
        clear_w = 1'b0;
        w_sel = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        n_checks++; if (s_ready !== 1'b1) begin n_fails++; $display("FAIL reset_s_ready: got %b expected 1", s_ready); end
        n_checks++; if (busy !== 1'b0) begin n_fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (r_valid !== 1'b0) begin n_fails++; $display("FAIL reset_r_valid: got %b expected 0", r_valid); end
        n_checks++; if (r_result !== 1'b0 || r_error !== 1'b0) begin n_fails++; $display("FAIL reset_result: got %b/%b expected 0/0", r_result, r_error); end
        n_checks++; if (err_count !== 8'd0) begin n_fails++; $display("FAIL reset_err_count: got %0d expected 0", err_count); end
        for (int i = 0; i < 8; i++) begin
            read_w(i, v);
            n_checks++; if (v !== 8'h00) begin n_fails++; $display("FAIL reset_w%0d: got %h expected 00", i, v); end
        end
    endtask

    task automatic test_infer();
        int rv_t, rdy_t;
        logic res, err;
        logic [7:0] v;
        // weights 0, threshold 0: sum 0 >= 0
        run_sample(8'hFF, 1'b0, 1'b0, 8'h00, rv_t, rdy_t, res, err);
        n_checks++; if (rv_t !== 9) begin n_fails++; $display("FAIL infer_rv_cycle: got %0d expected 9", rv_t); end
        n_checks++; if (rdy_t !== 10) begin n_fails++; $display("FAIL infer_ready_cycle: got %0d expected 10", rdy_t); end
        n_checks++; if (res !== 1'b1 || err !== 1'b0) begin n_fails++; $display("FAIL infer_result: got %b/%b expected 1/0", res, err); end
        n_checks++; if (r_result !== 1'b1) begin n_fails++; $display("FAIL infer_hold: got %b expected 1", r_result); end
        for (int i = 0; i < 8; i++) begin
            read_w(i, v);
            n_checks++; if (v !== 8'h00) begin n_fails++; $display("FAIL infer_w%0d: got %h expected 00", i, v); end
        end
        n_checks++; if (err_count !== 8'd0) begin n_fails++; $display("FAIL infer_err_count: got %0d expected 0", err_count); end
    endtask

    task automatic test_train();
        int rv_t, rdy_t;
        logic res, err;
        logic [7:0] v;
        logic [7:0] exp_w [8];
        // sum 0 >= 0 -> 1, label 0 -> error, w0/w2 step down
        run_sample(8'h05, 1'b0, 1'b1, 8'h00, rv_t, rdy_t, res, err);
        n_checks++; if (rv_t !== 9) begin n_fails++; $display("FAIL train_rv_cycle: got %0d expected 9", rv_t); end
        n_checks++; if (rdy_t !== 11) begin n_fails++; $display("FAIL train_ready_cycle: got %0d expected 11", rdy_t); end
        n_checks++; if (res !== 1'b1 || err !== 1'b1) begin n_fails++; $display("FAIL train_result: got %b/%b expected 1/1", res, err); end
        n_checks++; if (r_error !== 1'b1) begin n_fails++; $display("FAIL train_err_hold: got %b expected 1", r_error); end
        exp_w = '{8'hFF, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        for (int i = 0; i < 8; i++) begin
            read_w(i, v);
            n_checks++; if (v !== exp_w[i]) begin n_fails++; $display("FAIL train_w%0d: got %h expected %h", i, v, exp_w[i]); end
        end
        n_checks++; if (err_count !== 8'd1) begin n_fails++; $display("FAIL train_err_count: got %0d expected 1", err_count); end
        // w1 = 0 -> sum 0 >= 0 -> 1 matches label 1: no update
        run_sample(8'h02, 1'b1, 1'b1, 8'h00, rv_t, rdy_t, res, err);
        n_checks++; if (res !== 1'b1 || err !== 1'b0 || rdy_t !== 10) begin n_fails++; $display("FAIL train_match: got %b/%b ready %0d expected 1/0 ready 10", res, err, rdy_t); end
        // w0 = -1 -> sum -1 < 0 -> 0, label 1 -> error, w0 steps up to 0
        run_sample(8'h01, 1'b1, 1'b1, 8'h00, rv_t, rdy_t, res, err);
        n_checks++; if (res !== 1'b0 || err !== 1'b1 || rdy_t !== 11) begin n_fails++; $display("FAIL train_up: got %b/%b ready %0d expected 0/1 ready 11", res, err, rdy_t); end
        read_w(0, v);
        n_checks++; if (v !== 8'h00) begin n_fails++; $display("FAIL train_up_w0: got %h expected 00", v); end
        n_checks++; if (err_count !== 8'd2) begin n_fails++; $display("FAIL train_up_err_count: got %0d expected 2", err_count); end
    endtask

    task automatic test_threshold_boundary();
        int rv_t, rdy_t;
        logic res, err;
        logic [7:0] v;
        // weights now w0=0, w2=-1; s_in=05 sums to -1
        run_sample(8'h05, 1'b0, 1'b0, 8'hFF, rv_t, rdy_t, res, err);
        n_checks++; if (res !== 1'b1) begin n_fails++; $display("FAIL thr_eq: got %b expected 1 (-1 >= -1)", res); end
        run_sample(8'h05, 1'b0, 1'b0, 8'h00, rv_t, rdy_t, res, err);
        n_checks++; if (res !== 1'b0) begin n_fails++; $display("FAIL thr_above: got %b expected 0 (-1 >= 0)", res); end
        run_sample(8'h05, 1'b0, 1'b0, 8'h80, rv_t, rdy_t, res, err);
        n_checks++; if (res !== 1'b1) begin n_fails++; $display("FAIL thr_min: got %b expected 1 (-1 >= -128)", res); end
        run_sample(8'h05, 1'b1, 1'b0, 8'h7F, rv_t, rdy_t, res, err);
        n_checks++; if (res !== 1'b0 || err !== 1'b0 || rdy_t !== 10) begin n_fails++; $display("FAIL thr_max: got %b/%b ready %0d expected 0/0 ready 10", res, err, rdy_t); end
        read_w(2, v);
        n_checks++; if (v !== 8'hFF) begin n_fails++; $display("FAIL thr_w2_kept: got %h expected ff", v); end
        n_checks++; if (err_count !== 8'd2) begin n_fails++; $display("FAIL thr_err_count: got %0d expected 2", err_count); end
    endtask

    task automatic test_saturation();
        int rv_t, rdy_t, bad;
        logic res, err;
        logic [7:0] v;
        clear_w = 1'b1;
        tick();
        clear_w = 1'b0;
        n_checks++; if (err_count !== 8'd0) begin n_fails++; $display("FAIL sat_clear_err_count: got %0d expected 0", err_count); end
        read_w(2, v);
        n_checks++; if (v !== 8'h00) begin n_fails++; $display("FAIL sat_clear_w2: got %h expected 00", v); end
        bad = 0;
        // threshold -128: every sample answers 1 against label 0
        for (int k = 1; k <= 300; k++) begin
            run_sample(8'h01, 1'b0, 1'b1, 8'h80, rv_t, rdy_t, res, err);
            if (res !== 1'b1 || err !== 1'b1 || rv_t !== 9 || rdy_t !== 11) bad++;
            if (k == 127) begin
                read_w(0, v);
                n_checks++; if (v !== 8'h81) begin n_fails++; $display("FAIL sat_w0_127: got %h expected 81", v); end
                n_checks++; if (err_count !== 8'd127) begin n_fails++; $display("FAIL sat_err_127: got %0d expected 127", err_count); end
            end
        end
        n_checks++; if (bad !== 0) begin n_fails++; $display("FAIL sat_samples: got %0d bad samples expected 0", bad); end
        read_w(0, v);
        n_checks++; if (v !== 8'h80) begin n_fails++; $display("FAIL sat_w0: got %h expected 80", v); end
        n_checks++; if (err_count !== 8'd255) begin n_fails++; $display("FAIL sat_err_count: got %0d expected 255", err_count); end
        for (int i = 1; i < 8; i++) begin
            read_w(i, v);
            n_checks++; if (v !== 8'h00) begin n_fails++; $display("FAIL sat_w%0d: got %h expected 00", i, v); end
        end
    endtask

    task automatic test_backpressure();
        int hs, rv, ones, n;
        // w0=-128, threshold -127: captured s_in=01 gives 0, s_in=00 would give 1
        threshold = 8'h81;
        s_train = 1'b0;
        s_label = 1'b0;
        hs = 0;
        rv = 0;
        ones = 0;
        for (int c = 0; c < 30; c++) begin
            s_in = (c % 2 == 0) ? 8'h01 : 8'h00;
            s_valid = 1'b1;
            if (s_ready === 1'b1) hs++;
            if (r_valid === 1'b1) begin
                rv++;
                if (r_result !== 1'b0) ones++;
            end
            tick();
        end
        s_valid = 1'b0;
        n_checks++; if (hs !== 3) begin n_fails++; $display("FAIL bp_captures: got %0d expected 3", hs); end
        n_checks++; if (rv !== 3) begin n_fails++; $display("FAIL bp_results: got %0d expected 3", rv); end
        n_checks++; if (ones !== 0) begin n_fails++; $display("FAIL bp_captured_data: got %0d results of 1 expected 0", ones); end
        n_checks++; if (busy !== 1'b0) begin n_fails++; $display("FAIL bp_idle: got busy %b expected 0", busy); end

        // clear_w together with s_valid: clear wins, sample waits one cycle
        w_sel = 3'd0;
        clear_w = 1'b1;
        s_valid = 1'b1;
        s_in = 8'h01;
        #1;
        n_checks++; if (s_ready !== 1'b0) begin n_fails++; $display("FAIL clr_s_ready: got %b expected 0", s_ready); end
        tick();
        n_checks++; if (busy !== 1'b0) begin n_fails++; $display("FAIL clr_busy: got %b expected 0", busy); end
        n_checks++; if (err_count !== 8'd0) begin n_fails++; $display("FAIL clr_err_count: got %0d expected 0", err_count); end
        n_checks++; if (w_rd !== 8'h00) begin n_fails++; $display("FAIL clr_w0: got %h expected 00", w_rd); end
        clear_w = 1'b0;
        #1;
        n_checks++; if (s_ready !== 1'b1) begin n_fails++; $display("FAIL clr_ready_after: got %b expected 1", s_ready); end
        tick();
        s_valid = 1'b0;
        n_checks++; if (busy !== 1'b1) begin n_fails++; $display("FAIL clr_accepted: got busy %b expected 1", busy); end
        n = 0;
        while (s_ready !== 1'b1 && n < 15) begin
            tick();
            n++;
        end
        n_checks++; if (s_ready !== 1'b1) begin n_fails++; $display("FAIL clr_done: got s_ready %b expected 1", s_ready); end
    endtask

    task automatic test_reset_mid();
        int rv_t, rdy_t, rv;
        logic res, err;
        logic [7:0] v;
        // weights 0, threshold 0: answer 1 vs label 0 -> w0=-1, err_count=1
        run_sample(8'h01, 1'b0, 1'b1, 8'h00, rv_t, rdy_t, res, err);
        read_w(0, v);
        n_checks++; if (v !== 8'hFF || err_count !== 8'd1) begin n_fails++; $display("FAIL rst_pre: got w0 %h errs %0d expected ff 1", v, err_count); end
        s_in = 8'hFF;
        s_label = 1'b0;
        s_train = 1'b1;
        s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
        tick();
        tick();
        tick();
        n_checks++; if (busy !== 1'b1) begin n_fails++; $display("FAIL rst_busy_t4: got %b expected 1", busy); end
        reset = 1'b1;
        #1;
        n_checks++; if (busy !== 1'b0 || s_ready !== 1'b1 || r_valid !== 1'b0) begin n_fails++; $display("FAIL rst_async: got busy %b ready %b r_valid %b expected 0 1 0", busy, s_ready, r_valid); end
        tick();
        reset = 1'b0;
        w_sel = 3'd0;
        tick();
        n_checks++; if (w_rd !== 8'h00) begin n_fails++; $display("FAIL rst_w0: got %h expected 00", w_rd); end
        n_checks++; if (err_count !== 8'd0) begin n_fails++; $display("FAIL rst_err_count: got %0d expected 0", err_count); end
        rv = 0;
        for (int c = 0; c < 12; c++) begin
            if (r_valid === 1'b1) rv++;
            tick();
        end
        n_checks++; if (rv !== 0 || busy !== 1'b0) begin n_fails++; $display("FAIL rst_no_result: got %0d strobes busy %b expected 0 0", rv, busy); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_infer();
        test_train();
        test_threshold_boundary();
        test_saturation();
        test_backpressure();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
